hdlc_senddata: RTL and testbench
================================

HDLC_SENDDATA -- requirements
Module: hdlc_senddata

Interface
REQ-001 The block SHALL have parameter DATA_W, default 56, giving the payload width in bits.
REQ-002 The block SHALL have parameter FLAG, default 8'h7E, giving the opening and closing flag octet.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst.
REQ-004 Port clk  input  1  is the single clock; every register SHALL update on its rising edge.
REQ-005 Port rst  input  1  is the asynchronous active-low reset; rst=0 forces reset state immediately, independent of clk.
REQ-006 Port start  input  1  is the frame request; it is sampled only in IDLE.
REQ-007 Port in_data  input  DATA_W  is the payload; it is captured on the accepting edge and SHALL NOT be sampled afterwards.
REQ-008 Port tx  output  1  is the registered serial line, one bit per clk.
REQ-009 Port is_send  output  1  SHALL be high while a frame is on tx; it drives the receiver's is_send input.
REQ-010 Port busy  output  1  SHALL equal is_send; it is provided for the upstream handshake.
REQ-011 Port done  output  1  is a one-cycle pulse that marks completion of a frame.

Function
REQ-012 The FSM SHALL have the states IDLE, OPEN, DATA and CLOSE, with a 7-bit bit counter cnt.
REQ-013 In IDLE with start=1 on edge N, the block SHALL load in_data into a DATA_W shift register, enter OPEN with cnt=0, and drive tx=FLAG[7] from cycle N+1.
REQ-014 In OPEN, tx SHALL be FLAG[7-cnt] (MSB first); after cnt=7 the FSM SHALL enter DATA with cnt=0.
REQ-015 In DATA, tx SHALL be the shift-register MSB; the register SHALL shift left by one each cycle, zero-filled.
REQ-016 After cnt=DATA_W-1 in DATA, the FSM SHALL enter CLOSE with cnt=0.
REQ-017 In CLOSE, tx SHALL be FLAG[7-cnt]; after cnt=7 the FSM SHALL return to IDLE.
REQ-018 Frame length SHALL be exactly 8+DATA_W+8 cycles (72 at the default): tx is driven from cycle N+1 through N+72.
REQ-019 The payload SHALL be sent verbatim, with no zero-bit stuffing; the downstream receiver does not destuff.
REQ-020 is_send and busy SHALL be 1 in every OPEN, DATA and CLOSE cycle and 0 in IDLE.
REQ-021 done SHALL be 1 for exactly one cycle, the first IDLE cycle after CLOSE (cycle N+73).
REQ-022 In IDLE, tx SHALL be 1 (line mark).
REQ-023 Any start seen outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-024 A change on in_data while busy SHALL NOT affect the frame in flight.
REQ-025 start=1 in the done cycle SHALL be accepted, so the next frame's first flag bit appears at N+74; the minimum inter-frame gap is one mark bit.
REQ-026 cnt SHALL never exceed max(7, DATA_W-1); it SHALL NOT wrap during a frame.
REQ-027 DATA_W SHALL be in the range 1..127; other values are illegal.

Reset
REQ-028 While rst=0, outputs SHALL be tx=1, is_send=0, busy=0 and done=0, with state=IDLE, cnt=0 and the shift register at 0.
REQ-029 Reset asserted mid-frame SHALL abort the frame at once: no further flag or data bits and no done pulse.
REQ-030 The first start accepted after rst rises SHALL produce a complete, correct frame.

Verification
REQ-031 Basic frame: in_data=56'h0123456789ABCD, one-cycle start -> tx over N+1..N+72 = 01111110, the payload MSB first, then 01111110; done=1 only at N+73; busy high for 72 cycles.
REQ-032 Loopback: connect tx to hdlc_recivedata rx on the same clk with in_data=56'hA5A5A5A5A5A5A5 -> receiver out_data=64'h7EA5A5A5A5A5A5A5.
REQ-033 Ignored start: pulse start at N+10 and N+40 while busy, changing in_data each time -> exactly one frame, carrying the original payload; done pulses once.
REQ-034 Back-to-back: hold start=1 continuously -> frames begin at N+1 and N+74; tx=1 at N+73; done pulses at N+73 and N+146.
REQ-035 Mid-frame reset: rst=0 at N+30 for 3 cycles -> tx=1, busy=0 and done=0 immediately; a new start afterwards yields a full 72-bit frame.
REQ-036 Edge payloads: in_data all-zeros then all-ones -> 56 zeros or 56 ones between the flags, with no inserted bits.

Source files
------------

// File: rtl/hdlc_senddata.sv
// hdlc_senddata: serialises one DATA_W-bit payload as a raw HDLC-style frame.
// The frame is an opening FLAG octet, the payload MSB first, and a closing FLAG
// octet. Payload bits go out unmodified, with no zero-bit stuffing, because the
// matching receiver does not destuff. DATA_W must lie in 1..127 so that the
// 7-bit bit counter can reach DATA_W-1.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line at mark (tx=1); waiting for start; done pulses on entry
// OPEN  | opening flag on tx, FLAG[7-cnt]
// DATA  | payload on tx, MSB first, from the shift register
// CLOSE | closing flag on tx, FLAG[7-cnt]
//
// tx is registered. Each edge loads the bit that belongs to the state and
// count being entered, so the first flag bit appears in the cycle right after
// the accepting edge.
module hdlc_senddata #(
  parameter int          DATA_W = 56,
  parameter logic [7:0]  FLAG   = 8'h7E
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx,
  output logic              is_send,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    DATA  = 2'd2,
    CLOSE = 2'd3
  } state_t;

  localparam logic [6:0] FLAG_LAST = 7'd7;
  localparam logic [6:0] DATA_LAST = 7'(DATA_W - 1);

  state_t            state;
  logic [6:0]        cnt;
  logic [DATA_W-1:0] shreg;

  // The upstream handshake sees the same signal that gates the receiver.
  assign busy = is_send;

  // Frame sequencer with registered tx, is_send and done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
      is_send <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            // The payload is captured only here. Later changes on in_data
            // cannot reach the frame in flight.
            shreg   <= in_data;
            state   <= OPEN;
            cnt     <= '0;
            tx      <= FLAG[7];
            is_send <= 1'b1;
          end
        end

        OPEN: begin
          if (cnt == FLAG_LAST) begin
            // The first payload bit leaves now. The register shifts so that
            // its MSB always holds the next bit to send.
            state <= DATA;
            cnt   <= '0;
            tx    <= shreg[DATA_W-1];
            shreg <= shreg << 1;
          end else begin
            cnt <= cnt + 7'd1;
            tx  <= FLAG[3'd6 - cnt[2:0]];
          end
        end

        DATA: begin
          if (cnt == DATA_LAST) begin
            state <= CLOSE;
            cnt   <= '0;
            tx    <= FLAG[7];
          end else begin
            cnt   <= cnt + 7'd1;
            tx    <= shreg[DATA_W-1];
            shreg <= shreg << 1;
          end
        end

        CLOSE: begin
          if (cnt == FLAG_LAST) begin
            // Return to mark. The done cycle is itself IDLE, so a start seen
            // in it is accepted and leaves a single mark bit between frames.
            state   <= IDLE;
            cnt     <= '0;
            tx      <= 1'b1;
            is_send <= 1'b0;
            done    <= 1'b1;
          end else begin
            cnt <= cnt + 7'd1;
            tx  <= FLAG[3'd6 - cnt[2:0]];
          end
        end

        default: begin
          state   <= IDLE;
          cnt     <= '0;
          tx      <= 1'b1;
          is_send <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hdlc_senddata.sv
// Testbench for hdlc_senddata (default DATA_W=56, FLAG=8'h7E).
// The stimulus pushes hand-written 72-bit frames and their accept cycles into
// a queue. A negedge monitor collects every busy window and checks it against
// the head of that queue.
module tb_hdlc_senddata;

  logic        clk;
  logic        rst;
  logic        start;
  logic [55:0] in_data;
  logic        tx;
  logic        is_send;
  logic        busy;
  logic        done;

  hdlc_senddata #(.DATA_W(56), .FLAG(8'h7E)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_data (in_data),
    .tx      (tx),
    .is_send (is_send),
    .busy    (busy),
    .done    (done)
  );

  typedef struct {
    logic [71:0] bits;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: collects each busy window and compares it against the queue head.
  logic        prev_busy = 1'b0;
  logic [71:0] sh        = '0;
  int          nbits     = 0;
  int          first_cyc = 0;
  logic        iss_bad   = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_busy = 1'b0;
      nbits     = 0;
      iss_bad   = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) begin
          first_cyc = cyc;
          nbits     = 0;
          sh        = '0;
          iss_bad   = 1'b0;
        end
        sh = {sh[70:0], tx};
        nbits++;
        if (is_send !== busy) iss_bad = 1'b1;
        if (done) chk("done_while_busy", 72'(done), 72'd0);
      end else if (prev_busy) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: got frame %h at cycle %0d, required no frame", sh, first_cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("frame_bits", sh, e.bits);
          chk("frame_len", 72'(nbits), 72'd72);
          chk("frame_start_cyc", 72'(first_cyc), 72'(e.acc));
          chk("done_pulse", 72'(done), 72'd1);
          chk("tx_mark_after", 72'(tx), 72'd1);
          chk("is_send_eq_busy", 72'(iss_bad), 72'd0);
        end
      end else if (done) begin
        chk("spurious_done", 72'(done), 72'd0);
      end
      prev_busy = busy;
    end
  end

  task automatic issue(input logic [55:0] d, input logic [71:0] e, input bit push);
    @(negedge clk);
    start   = 1'b1;
    in_data = d;
    if (push) exp_q.push_back('{bits: e, acc: cyc + 1});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    chk(name, 72'(exp_q.size() == 0 && !busy), 72'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a;
    rst     = 1'b0;
    start   = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 72'(tx), 72'd1);
    chk("reset_busy", 72'(busy), 72'd0);
    chk("reset_is_send", 72'(is_send), 72'd0);
    chk("reset_done", 72'(done), 72'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame.
    issue(56'h0123456789ABCD, 72'h7E_0123456789ABCD_7E, 1'b1);
    wait_idle("drain_basic");

    // Loopback payload: the receiver sees 64'h7EA5A5A5A5A5A5A5 as the first 64 bits.
    issue(56'hA5A5A5A5A5A5A5, 72'h7E_A5A5A5A5A5A5A5_7E, 1'b1);
    wait_idle("drain_loopback");

    // Starts while busy are ignored, and the in_data changes do not leak into the frame.
    issue(56'h11223344556677, 72'h7E_11223344556677_7E, 1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; in_data = 56'hFFFFFFFFFFFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1; in_data = 56'h00000000000000;
    @(negedge clk);
    start = 1'b0;
    wait_idle("drain_ignored");

    // Back-to-back with start held high: the second frame is accepted 73 edges later.
    @(negedge clk);
    start   = 1'b1;
    in_data = 56'h0F0F0F0F0F0F0F;
    a       = cyc + 1;
    exp_q.push_back('{bits: 72'h7E_0F0F0F0F0F0F0F_7E, acc: a});
    exp_q.push_back('{bits: 72'h7E_F0F0F0F0F0F0F0_7E, acc: a + 73});
    @(negedge clk);
    in_data = 56'hF0F0F0F0F0F0F0;
    for (int i = 0; i < 200 && cyc < a + 73; i++) @(negedge clk);
    start = 1'b0;
    wait_idle("drain_b2b");

    // Mid-frame reset aborts the frame. The next start gives a full frame.
    issue(56'hDEADBEEFCAFE12, 72'h0, 1'b0);
    repeat (28) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_tx", 72'(tx), 72'd1);
    chk("abort_busy", 72'(busy), 72'd0);
    chk("abort_done", 72'(done), 72'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 72'(busy | done), 72'd0);
    issue(56'hDEADBEEFCAFE12, 72'h7E_DEADBEEFCAFE12_7E, 1'b1);
    wait_idle("drain_after_reset");

    // Edge payloads: no bits are inserted.
    issue(56'h00000000000000, 72'h7E_00000000000000_7E, 1'b1);
    wait_idle("drain_zeros");
    issue(56'hFFFFFFFFFFFFFF, 72'h7E_FFFFFFFFFFFFFF_7E, 1'b1);
    wait_idle("drain_ones");

    repeat (5) @(negedge clk);
    chk("queue_empty", 72'(exp_q.size()), 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
